keystream_tx_seq: RTL and testbench
===================================

KEYSTREAM_TX_SEQ -- requirements
Module: keystream_tx_seq

Interface
REQ-001 Parameter NUM_BLOCKS, default 1: number of 64-byte keystream blocks emitted per start pulse; legal range 1..65535.
REQ-002 Parameter START_INDEX, default 0: 64-bit block index loaded on each accepted start.
REQ-003 hwclk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request to begin a run; ignored while busy=1.
REQ-006 busy  out  1  high from the cycle after an accepted start until the run completes.
REQ-007 run_done  out  1  one-cycle pulse on run completion.
REQ-008 core_start  out  1  cipher-core start strobe, one cycle wide.
REQ-009 core_index  out  64  block index presented to the core; held stable while the core runs.
REQ-010 core_done  in  1  core result valid; sampled only in WAIT_CORE.
REQ-011 core_out  in  512  core keystream block; byte k = core_out[8k+7:8k].
REQ-012 tx_byte  out  8  byte presented to the UART transmitter.
REQ-013 tx_send  out  1  transmit request level.
REQ-014 tx_en  out  1  transmitter enable level; equals tx_send.
REQ-015 tx_done  in  1  transmitter idle flag from the baud-clock domain; high=idle.
REQ-016 blocks_sent  out  16  count of blocks fully transmitted in the current run.

Function
REQ-017 tx_done shall pass through a 2-flop synchronizer; only the synchronized value shall be used.
REQ-018 States: IDLE, KICK, WAIT_CORE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE, NEXT.
REQ-019 IDLE: on start=1, load core_index=START_INDEX, clear blocks_sent, set busy, go to KICK.
REQ-020 KICK: pulse core_start for exactly one cycle, then go to WAIT_CORE.
REQ-021 WAIT_CORE: on core_done=1, capture core_out into a 512-bit holding register, clear byte pointer, go to LOAD.
REQ-022 LOAD: wait for synchronized tx_done=1; then drive tx_byte from the holding register at the byte pointer and go to SEND.
REQ-023 SEND: assert tx_send and tx_en, then go to WAIT_BUSY.
REQ-024 WAIT_BUSY: hold tx_send until synchronized tx_done=0, then go to WAIT_IDLE.
REQ-025 WAIT_IDLE: on synchronized tx_done=1, deassert tx_send and tx_en. If bytes remain in the block, advance the pointer and go to LOAD; otherwise go to NEXT.
REQ-026 NEXT: increment blocks_sent and core_index; 64-bit index wraps modulo 2^64.
REQ-027 From NEXT: if blocks_sent+1 < NUM_BLOCKS, go to KICK; else clear busy, pulse run_done for one cycle, return to IDLE.
REQ-028 tx_byte shall stay stable from LOAD exit until WAIT_IDLE exit.
REQ-029 The holding register shall be loaded only in WAIT_CORE, so core_out may change during transmission without effect.
REQ-030 When start and run completion fall in the same cycle, start shall be ignored.
REQ-031 Byte order: byte 0 first, byte 63 last.

Reset
REQ-032 Asserting rst_n=0 at any point, including mid-byte, shall immediately force IDLE, clear the synchronizer and byte pointer, and drive all outputs to 0 (core_index=START_INDEX).
REQ-033 After reset release, no core_start or tx_send shall occur until an accepted start.

Configuration
REQ-034 With KEYSTREAM_TX_HEX_EN defined, each byte shall be sent as two lowercase ASCII hex characters, high nibble first ('0'-'9'=0x30-0x39, 'a'-'f'=0x61-0x66), followed by 0x0A after byte 63, giving 129 characters per block.
REQ-035 Without KEYSTREAM_TX_HEX_EN, raw bytes shall be sent, 64 per block, with no terminator.

Verification
REQ-036 Reset mid-run: rst_n low during WAIT_BUSY -> all outputs 0 next edge; run ends with no run_done pulse.
REQ-037 NUM_BLOCKS=1, core_out=512'h3F..0201 (byte k=k+1 for k<63, byte 63=0x3F), raw mode -> tx_byte sequence 0x01..0x3F then stop, run_done once, blocks_sent=1.
REQ-038 NUM_BLOCKS=3, START_INDEX=64'hFFFF_FFFF_FFFF_FFFE -> core_index values FFFE, FFFF, 0000_0000_0000_0000, exactly 3 core_start pulses, 192 bytes.
REQ-039 Hex mode, byte0=0xA5 -> first characters 0x61, 0x35; the 129th character is 0x0A.
REQ-040 tx_done held low for 10 ms after LOAD -> FSM stays in LOAD, tx_send stays 0, no byte lost.
REQ-041 start pulsed while busy, and simultaneously with run_done -> ignored; exactly one run_done per accepted start.

Source files
------------

// File: rtl/keystream_tx_seq.sv
// Keystream sequencer: runs the cipher core for NUM_BLOCKS blocks and streams each block to a UART.
// Define KEYSTREAM_TX_HEX_EN to send lowercase ASCII hex plus a newline per block instead of raw bytes.
module keystream_tx_seq #(
  parameter int unsigned NUM_BLOCKS  = 1,
  parameter logic [63:0] START_INDEX = '0
) (
  input  logic         hwclk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         run_done,
  output logic         core_start,
  output logic [63:0]  core_index,
  input  logic         core_done,
  input  logic [511:0] core_out,
  output logic [7:0]   tx_byte,
  output logic         tx_send,
  output logic         tx_en,
  input  logic         tx_done,
  output logic [15:0]  blocks_sent
);

  typedef enum logic [2:0] {
    IDLE, KICK, WAIT_CORE, LOAD, SEND, WAIT_BUSY, WAIT_IDLE, NEXT
  } state_t;

`ifdef KEYSTREAM_TX_HEX_EN
  localparam logic [7:0] LAST_CHAR = 8'd128;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Two characters per byte, high nibble first; character 128 is the block terminator.
  function automatic logic [7:0] char_at(input logic [511:0] h, input logic [7:0] p);
    if (p == LAST_CHAR) return 8'h0A;
    return p[0] ? hex_ascii(h[{p[6:1], 3'b000} +: 4]) : hex_ascii(h[{p[6:1], 3'b100} +: 4]);
  endfunction
`else
  localparam logic [7:0] LAST_CHAR = 8'd63;

  function automatic logic [7:0] char_at(input logic [511:0] h, input logic [5:0] p);
    return h[{p, 3'b000} +: 8];
  endfunction
`endif

  localparam logic [16:0] NB17 = 17'(NUM_BLOCKS);

  state_t         state, state_nx;
  logic           tx_done_meta, tx_done_sync;
  logic [511:0]   hold;
  logic [7:0]     ptr;
  logic [7:0]     char_nx;
  logic           accept;
  logic           more_blocks;

  // A start coinciding with the completion pulse is dropped, not queued.
  assign accept      = start && !run_done;
  assign more_blocks = ({1'b0, blocks_sent} + 17'd1) < NB17;

`ifdef KEYSTREAM_TX_HEX_EN
  assign char_nx = char_at(hold, ptr);
`else
  assign char_nx = char_at(hold, ptr[5:0]);
`endif

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (accept) state_nx = KICK;
      KICK:      state_nx = WAIT_CORE;
      WAIT_CORE: if (core_done) state_nx = LOAD;
      LOAD:      if (tx_done_sync) state_nx = SEND;
      SEND:      state_nx = WAIT_BUSY;
      WAIT_BUSY: if (!tx_done_sync) state_nx = WAIT_IDLE;
      WAIT_IDLE: if (tx_done_sync) state_nx = (ptr == LAST_CHAR) ? NEXT : LOAD;
      NEXT:      state_nx = more_blocks ? KICK : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done_meta <= 1'b0;
      tx_done_sync <= 1'b0;
      core_index   <= START_INDEX;
      blocks_sent  <= '0;
      hold         <= '0;
      ptr          <= '0;
      tx_byte      <= '0;
      run_done     <= 1'b0;
    end else begin
      tx_done_meta <= tx_done;
      tx_done_sync <= tx_done_meta;
      run_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            core_index  <= START_INDEX;
            blocks_sent <= '0;
          end
        end
        WAIT_CORE: begin
          if (core_done) begin
            hold <= core_out;
            ptr  <= '0;
          end
        end
        LOAD: begin
          if (tx_done_sync) tx_byte <= char_nx;
        end
        WAIT_IDLE: begin
          if (tx_done_sync && (ptr != LAST_CHAR)) ptr <= ptr + 8'd1;
        end
        NEXT: begin
          blocks_sent <= blocks_sent + 16'd1;
          core_index  <= core_index + 64'd1;
          if (!more_blocks) run_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign core_start = (state == KICK);
  assign tx_send    = (state == SEND) || (state == WAIT_BUSY) || (state == WAIT_IDLE);
  assign tx_en      = tx_send;

endmodule

// File: tb/tb_keystream_tx_seq.sv
// Directed bench: one single-block instance and one three-block instance with wrapping index,
// each driven by a small cipher-core and UART responder.
module tb_keystream_tx_seq;

`ifdef KEYSTREAM_TX_HEX_EN
  localparam int CPB = 129;
`else
  localparam int CPB = 64;
`endif

  logic         hwclk = 1'b0;
  logic         rst_n;
  logic [511:0] core_out;
  logic [1:0]   start_v, busy_v, rd_v, cs_v, cd_v, ts_v, te_v, td_raw, hold_low, tdin, ts_prev;
  logic [63:0]  ci [2];
  logic [7:0]   txb [2];
  logic [15:0]  bs [2];
  int           txc [2];
  int           cdc [2];
  int           cs_cnt [2];
  int           rd_cnt [2];
  int           ts_hi [2];
  logic [7:0]   q0 [$];
  logic [7:0]   q1 [$];
  logic [63:0]  idx_log [$];
  int           total = 0;
  int           bad = 0;

  always #5 hwclk = ~hwclk;

  assign tdin = td_raw & ~hold_low;

  keystream_tx_seq u1 (
    .hwclk(hwclk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .run_done(rd_v[0]),
    .core_start(cs_v[0]), .core_index(ci[0]), .core_done(cd_v[0]), .core_out(core_out),
    .tx_byte(txb[0]), .tx_send(ts_v[0]), .tx_en(te_v[0]), .tx_done(tdin[0]), .blocks_sent(bs[0])
  );

  keystream_tx_seq #(.NUM_BLOCKS(3), .START_INDEX(64'hFFFF_FFFF_FFFF_FFFE)) u3 (
    .hwclk(hwclk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .run_done(rd_v[1]),
    .core_start(cs_v[1]), .core_index(ci[1]), .core_done(cd_v[1]), .core_out(core_out),
    .tx_byte(txb[1]), .tx_send(ts_v[1]), .tx_en(te_v[1]), .tx_done(tdin[1]), .blocks_sent(bs[1])
  );

  // Core answers 4 cycles after its start strobe; UART goes busy on a rising tx_send for 6 cycles.
  always @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      td_raw  <= 2'b11;
      cd_v    <= 2'b00;
      ts_prev <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        txc[i] <= 0;
        cdc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        ts_prev[i] <= ts_v[i];
        cd_v[i]    <= 1'b0;
        if (cs_v[i]) cdc[i] <= 3;
        else if (cdc[i] != 0) begin
          cdc[i] <= cdc[i] - 1;
          if (cdc[i] == 1) cd_v[i] <= 1'b1;
        end
        if (ts_v[i] && !ts_prev[i]) begin
          td_raw[i] <= 1'b0;
          txc[i]    <= 6;
        end else if (txc[i] != 0) begin
          txc[i] <= txc[i] - 1;
          if (txc[i] == 1) td_raw[i] <= 1'b1;
        end
      end
    end
  end

  always @(posedge hwclk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (cs_v[i]) cs_cnt[i] <= cs_cnt[i] + 1;
        if (rd_v[i]) rd_cnt[i] <= rd_cnt[i] + 1;
        if (ts_v[i]) ts_hi[i]  <= ts_hi[i] + 1;
      end
      if (cs_v[1]) idx_log.push_back(ci[1]);
      if (ts_v[0] && !ts_prev[0]) q0.push_back(txb[0]);
      if (ts_v[1] && !ts_prev[1]) q1.push_back(txb[1]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input logic [511:0] blk, input int n);
`ifdef KEYSTREAM_TX_HEX_EN
    logic [3:0] nib;
    if (n == 128) return 8'h0A;
    nib = n[0] ? blk[8*(n/2) +: 4] : blk[8*(n/2)+4 +: 4];
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h61 + {4'h0, nib} - 8'd10);
`else
    return blk[8*n +: 8];
`endif
  endfunction

  logic [511:0] pat1, pat2;
  int n, snap_rd, snap_cs, snap_q;

  initial begin
    for (int k = 0; k < 64; k++) pat1[8*k +: 8] = (k < 63) ? 8'(k + 1) : 8'h3F;
    pat2 = pat1;
    pat2[7:0] = 8'hA5;
    rst_n = 1'b0; start_v = '0; hold_low = '0; core_out = pat1;
    repeat (3) @(negedge hwclk);

    // Reset state of both instances
    chk("rst busy", {62'd0, busy_v}, 64'd0);
    chk("rst run_done", {62'd0, rd_v}, 64'd0);
    chk("rst core_start", {62'd0, cs_v}, 64'd0);
    chk("rst tx_send", {62'd0, ts_v}, 64'd0);
    chk("rst tx_en", {62'd0, te_v}, 64'd0);
    chk("rst tx_byte", {48'd0, txb[0], txb[1]}, 64'd0);
    chk("rst blocks_sent", {32'd0, bs[0], bs[1]}, 64'd0);
    chk("rst core_index u1", ci[0], 64'd0);
    chk("rst core_index u3", ci[1], 64'hFFFF_FFFF_FFFF_FFFE);
    rst_n = 1'b1;
    repeat (10) @(negedge hwclk);
    chk("post-reset core_start", 64'(cs_cnt[0] + cs_cnt[1]), 64'd0);
    chk("post-reset tx_send", 64'(ts_hi[0] + ts_hi[1]), 64'd0);

    // Single block, transmitter held not-idle for a long time first
    hold_low[0] = 1'b1;
    start_v[0] = 1'b1; @(negedge hwclk); start_v[0] = 1'b0;
    chk("A busy after start", {63'd0, busy_v[0]}, 64'd1);
    chk("A other idle", {63'd0, busy_v[1]}, 64'd0);
    repeat (30) @(negedge hwclk);
    core_out = '1;
    repeat (1970) @(negedge hwclk);
    chk("A hold tx_send", 64'(ts_hi[0]), 64'd0);
    chk("A hold no bytes", 64'(q0.size()), 64'd0);
    chk("A hold busy", {63'd0, busy_v[0]}, 64'd1);
    hold_low[0] = 1'b0;
    repeat (100) @(negedge hwclk);
    start_v[0] = 1'b1; @(negedge hwclk); start_v[0] = 1'b0;
    n = 0;
    while (!rd_v[0] && n < 20000) begin @(negedge hwclk); n++; end
    chk("A run_done seen", {63'd0, rd_v[0]}, 64'd1);
    chk("A busy at done", {63'd0, busy_v[0]}, 64'd0);
    chk("A blocks_sent", {48'd0, bs[0]}, 64'd1);
    chk("A core_index", ci[0], 64'd1);
    start_v[0] = 1'b1; @(negedge hwclk); start_v[0] = 1'b0;
    repeat (10) @(negedge hwclk);
    chk("A start at done ignored", {63'd0, busy_v[0]}, 64'd0);
    chk("A run_done count", 64'(rd_cnt[0]), 64'd1);
    chk("A core_start count", 64'(cs_cnt[0]), 64'd1);
    chk("A char count", 64'(q0.size()), 64'(CPB));
    if (q0.size() == CPB)
      for (int i = 0; i < CPB; i++)
        chk($sformatf("A char %0d", i), {56'd0, q0[i]}, {56'd0, exp_char(pat1, i)});

    // Reset while a byte is in flight
    core_out = pat2;
    snap_q = q0.size();
    start_v[0] = 1'b1; @(negedge hwclk); start_v[0] = 1'b0;
    n = 0;
    while (!(ts_v[0] && !td_raw[0]) && n < 200) begin @(negedge hwclk); n++; end
    chk("B reached wait_busy", {62'd0, ts_v[0], td_raw[0]}, 64'd2);
    chk("B first char", 64'(q0.size() > snap_q ? q0[snap_q] : 8'h00),
        64'(exp_char(pat2, 0)));
    snap_rd = rd_cnt[0];
    snap_cs = cs_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    chk("B async outputs", {57'd0, busy_v[0], rd_v[0], cs_v[0], ts_v[0], te_v[0], 2'b00}, 64'd0);
    chk("B async tx_byte/bs", {40'd0, txb[0], bs[0]}, 64'd0);
    chk("B async core_index", ci[0], 64'd0);
    @(posedge hwclk); #1;
    chk("B edge tx_send", {62'd0, ts_v[0], te_v[0]}, 64'd0);
    repeat (3) @(negedge hwclk);
    rst_n = 1'b1;
    snap_q = q0.size();
    repeat (20) @(negedge hwclk);
    chk("B no run_done", 64'(rd_cnt[0]), 64'(snap_rd));
    chk("B no core_start", 64'(cs_cnt[0]), 64'(snap_cs));
    chk("B no tx after reset", 64'(q0.size()), 64'(snap_q));
    chk("B idle after reset", {63'd0, busy_v[0]}, 64'd0);

    // Three blocks with wrapping index
    core_out = pat1;
    start_v[1] = 1'b1; @(negedge hwclk); start_v[1] = 1'b0;
    n = 0;
    while (!rd_v[1] && n < 40000) begin @(negedge hwclk); n++; end
    chk("C run_done seen", {63'd0, rd_v[1]}, 64'd1);
    chk("C blocks_sent", {48'd0, bs[1]}, 64'd3);
    chk("C final core_index", ci[1], 64'd1);
    repeat (5) @(negedge hwclk);
    chk("C core_start count", 64'(cs_cnt[1]), 64'd3);
    chk("C run_done count", 64'(rd_cnt[1]), 64'd1);
    chk("C index log size", 64'(idx_log.size()), 64'd3);
    if (idx_log.size() == 3) begin
      chk("C index 0", idx_log[0], 64'hFFFF_FFFF_FFFF_FFFE);
      chk("C index 1", idx_log[1], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("C index 2", idx_log[2], 64'h0);
    end
    chk("C char count", 64'(q1.size()), 64'(3 * CPB));
    if (q1.size() == 3 * CPB)
      for (int i = 0; i < 3 * CPB; i++)
        chk($sformatf("C char %0d", i), {56'd0, q1[i]}, {56'd0, exp_char(pat1, i % CPB)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
